// File: rtl/slope_tracker_pkg.sv
// Shared types and helpers for the slope tracker: FSM states, step classes
// and an order compare that works for both signed and unsigned samples.
package slope_tracker_pkg;

    typedef enum logic [1:0] {IDLE, UNKNOWN, RISING, FALLING} state_t;
    typedef enum logic [1:0] {FLAT, UP, DOWN} step_t;

    localparam int SAMPLE_MAX_W = 64;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    function automatic logic sample_greater(
        input logic [SAMPLE_MAX_W-1:0] a,
        input logic [SAMPLE_MAX_W-1:0] b,
        input int                      width,
        input logic                    is_signed
    );
        logic [SAMPLE_MAX_W-1:0] bias;
        bias = is_signed ? (SAMPLE_MAX_W'(1) << (width - 1)) : '0;
        return (a ^ bias) > (b ^ bias);
    endfunction

endpackage

// File: rtl/slope_tracker_step_classifier.sv
// Combinational step classifier: widened delta between the current and
// previous sample, compared against a zero-extended threshold.
module step_classifier
    import slope_tracker_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int THRESH_WIDTH = 12,
    parameter int SIGNED_DATA  = 1
) (
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH-1:0]   prev_sample,
    input  logic [THRESH_WIDTH-1:0] threshold,
    output step_t                   step
);

    // Wide enough that neither the delta nor the negated threshold can wrap.
    localparam int W = ((DATA_WIDTH > THRESH_WIDTH) ? DATA_WIDTH : THRESH_WIDTH) + 2;

    logic          din_sign;
    logic          prev_sign;
    logic signed [W-1:0] din_ext;
    logic signed [W-1:0] prev_ext;
    logic signed [W-1:0] thr_ext;
    logic signed [W-1:0] delta;

    assign din_sign  = (SIGNED_DATA != 0) && din[DATA_WIDTH-1];
    assign prev_sign = (SIGNED_DATA != 0) && prev_sample[DATA_WIDTH-1];
    assign din_ext   = {{(W-DATA_WIDTH){din_sign}}, din};
    assign prev_ext  = {{(W-DATA_WIDTH){prev_sign}}, prev_sample};
    assign thr_ext   = {{(W-THRESH_WIDTH){1'b0}}, threshold};
    assign delta     = din_ext - prev_ext;

    always_comb begin
        step = FLAT;
        if (delta > thr_ext) begin
            step = UP;
        end else if (delta < -thr_ext) begin
            step = DOWN;
        end
    end

endmodule

// File: rtl/slope_tracker.sv
// Rising/falling classifier for a sampled ADC stream with confirmation
// filtering, peak/valley capture and a turn event counter.
module slope_tracker
    import slope_tracker_pkg::*;
#(
    parameter int DATA_WIDTH    = 14,
    parameter int THRESH_WIDTH  = 12,
    parameter int CONFIRM_WIDTH = 8,
    parameter int SIGNED_DATA   = 1
) (
    input  logic                     adc_clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [THRESH_WIDTH-1:0]  threshold,
    input  logic [CONFIRM_WIDTH-1:0] confirm_len,
    output logic                     rising,
    output logic                     falling,
    output logic                     turn_pulse,
    output logic                     turn_is_peak,
    output logic [DATA_WIDTH-1:0]    extreme_value,
    output logic [31:0]              turn_count
);

    localparam logic IS_SIGNED = (SIGNED_DATA != 0);

    state_t                   state, state_n;
    step_t                    step;
    logic [CONFIRM_WIDTH-1:0] cnt, cnt_n, cnt_inc, eff_len, run_len;
    logic                     unknown_up, unknown_up_n;
    logic [DATA_WIDTH-1:0]    prev_sample, prev_n;
    logic [DATA_WIDTH-1:0]    tracker, tracker_n;
    logic [DATA_WIDTH-1:0]    rise_extreme, fall_extreme;
    logic                     pulse_n, peak_n;
    logic [DATA_WIDTH-1:0]    extreme_n;
    logic [31:0]              count_n;

    step_classifier #(
        .DATA_WIDTH   (DATA_WIDTH),
        .THRESH_WIDTH (THRESH_WIDTH),
        .SIGNED_DATA  (SIGNED_DATA)
    ) u_classifier (
        .din          (din),
        .prev_sample  (prev_sample),
        .threshold    (threshold),
        .step         (step)
    );

    // A zero confirmation length behaves as one; the counter saturates so a
    // long opposing run can never wrap back below the confirmation length.
    assign eff_len = (confirm_len == '0) ? CONFIRM_WIDTH'(1) : confirm_len;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CONFIRM_WIDTH'(1);

    assign rise_extreme = sample_greater(SAMPLE_MAX_W'(din), SAMPLE_MAX_W'(tracker),
                                         DATA_WIDTH, IS_SIGNED) ? din : tracker;
    assign fall_extreme = sample_greater(SAMPLE_MAX_W'(tracker), SAMPLE_MAX_W'(din),
                                         DATA_WIDTH, IS_SIGNED) ? din : tracker;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        unknown_up_n = unknown_up;
        prev_n       = prev_sample;
        tracker_n    = tracker;
        run_len      = '0;
        pulse_n      = 1'b0;
        peak_n       = turn_is_peak;
        extreme_n    = extreme_value;
        count_n      = turn_count;
        if (din_valid) begin
            prev_n = din;
            case (state)
                IDLE: state_n = UNKNOWN;
                UNKNOWN: begin
                    if (step != FLAT) begin
                        unknown_up_n = (step == UP);
                        run_len = (cnt != '0 && unknown_up == (step == UP)) ? cnt_inc
                                                                             : CONFIRM_WIDTH'(1);
                        if (run_len >= eff_len) begin
                            state_n   = (step == UP) ? RISING : FALLING;
                            tracker_n = din;
                            cnt_n     = '0;
                        end else begin
                            cnt_n = run_len;
                        end
                    end
                end
                RISING: begin
                    tracker_n = rise_extreme;
                    if (step == UP) begin
                        cnt_n = '0;
                    end else if (step == DOWN) begin
                        if (cnt_inc >= eff_len) begin
                            state_n   = FALLING;
                            pulse_n   = 1'b1;
                            peak_n    = 1'b1;
                            extreme_n = rise_extreme;
                            count_n   = turn_count + 32'd1;
                            tracker_n = din;
                            cnt_n     = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                FALLING: begin
                    tracker_n = fall_extreme;
                    if (step == DOWN) begin
                        cnt_n = '0;
                    end else if (step == UP) begin
                        if (cnt_inc >= eff_len) begin
                            state_n   = RISING;
                            pulse_n   = 1'b1;
                            peak_n    = 1'b0;
                            extreme_n = fall_extreme;
                            count_n   = turn_count + 32'd1;
                            tracker_n = din;
                            cnt_n     = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            unknown_up    <= 1'b0;
            prev_sample   <= '0;
            tracker       <= '0;
            rising        <= 1'b0;
            falling       <= 1'b0;
            turn_pulse    <= 1'b0;
            turn_is_peak  <= 1'b0;
            extreme_value <= '0;
            turn_count    <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            unknown_up    <= unknown_up_n;
            prev_sample   <= prev_n;
            tracker       <= tracker_n;
            rising        <= (state_n == RISING);
            falling       <= (state_n == FALLING);
            turn_pulse    <= pulse_n;
            turn_is_peak  <= peak_n;
            extreme_value <= extreme_n;
            turn_count    <= count_n;
        end
    end

endmodule

// File: tb/tb_slope_tracker.sv
// Directed, self-checking bench for slope_tracker with default parameters
// (14-bit signed samples, 12-bit threshold, 8-bit confirmation length).
module tb_slope_tracker;

    logic        adc_clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [13:0] din = '0;
    logic [11:0] threshold = '0;
    logic [7:0]  confirm_len = '0;
    logic        rising, falling, turn_pulse, turn_is_peak;
    logic [13:0] extreme_value;
    logic [31:0] turn_count;

    int total = 0;
    int bad = 0;

    slope_tracker dut (
        .adc_clk       (adc_clk),
        .rst           (rst),
        .din_valid     (din_valid),
        .din           (din),
        .threshold     (threshold),
        .confirm_len   (confirm_len),
        .rising        (rising),
        .falling       (falling),
        .turn_pulse    (turn_pulse),
        .turn_is_peak  (turn_is_peak),
        .extreme_value (extreme_value),
        .turn_count    (turn_count)
    );

    always #5 adc_clk = ~adc_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One valid sample followed by an idle half; outputs are readable on return.
    task automatic send(input logic [13:0] value);
        @(negedge adc_clk);
        din_valid = 1'b1;
        din = value;
        @(negedge adc_clk);
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge adc_clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(negedge adc_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rising !== 1'b0) begin bad++; $display("[TB] FAIL reset_rising got=%0b exp=0", rising); end
        total++; if (falling !== 1'b0) begin bad++; $display("[TB] FAIL reset_falling got=%0b exp=0", falling); end
        total++; if (turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulse got=%0b exp=0", turn_pulse); end
        total++; if (turn_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", turn_count); end
        total++; if (extreme_value !== 14'd0) begin bad++; $display("[TB] FAIL reset_extreme got=%0d exp=0", extreme_value); end
    endtask

    task automatic test_rise();
        threshold = 12'd10;
        confirm_len = 8'd3;
        send(14'd0);
        send(14'd20);
        send(14'd40);
        total++; if (rising !== 1'b0) begin bad++; $display("[TB] FAIL rise_early got=%0b exp=0", rising); end
        send(14'd60);
        total++; if (rising !== 1'b1) begin bad++; $display("[TB] FAIL rise_level got=%0b exp=1", rising); end
        total++; if (turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL rise_no_pulse got=%0b exp=0", turn_pulse); end
        total++; if (turn_count !== 32'd0) begin bad++; $display("[TB] FAIL rise_count got=%0d exp=0", turn_count); end
    endtask

    task automatic test_peak();
        for (int v = 80; v <= 200; v += 20) send(14'(v));
        send(14'd180);
        send(14'd160);
        total++; if (falling !== 1'b0 || turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL peak_early got=%0b%0b exp=00", falling, turn_pulse); end
        send(14'd140);
        total++; if (turn_pulse !== 1'b1) begin bad++; $display("[TB] FAIL peak_pulse got=%0b exp=1", turn_pulse); end
        total++; if (turn_is_peak !== 1'b1) begin bad++; $display("[TB] FAIL peak_flag got=%0b exp=1", turn_is_peak); end
        total++; if (extreme_value !== 14'd200) begin bad++; $display("[TB] FAIL peak_value got=%0d exp=200", extreme_value); end
        total++; if (falling !== 1'b1 || rising !== 1'b0) begin bad++; $display("[TB] FAIL peak_state got=r%0b f%0b exp=r0 f1", rising, falling); end
        total++; if (turn_count !== 32'd1) begin bad++; $display("[TB] FAIL peak_count got=%0d exp=1", turn_count); end
        @(negedge adc_clk);
        total++; if (turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL peak_pulse_width got=%0b exp=0", turn_pulse); end
    endtask

    task automatic test_noise();
        logic [13:0] noise [4] = '{14'd140, 14'd145, 14'd140, 14'd135};
        for (int i = 0; i < 4; i++) begin
            send(noise[i]);
            total++; if (falling !== 1'b1 || turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL noise_%0d got=f%0b p%0b exp=f1 p0", i, falling, turn_pulse); end
        end
    endtask

    task automatic test_glitch();
        logic [13:0] seq [6] = '{14'd120, 14'd100, 14'd130, 14'd110, 14'd140, 14'd160};
        for (int i = 0; i < 6; i++) send(seq[i]);
        total++; if (falling !== 1'b1 || turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL glitch_hold got=f%0b p%0b exp=f1 p0", falling, turn_pulse); end
        send(14'd180);
        total++; if (turn_pulse !== 1'b1) begin bad++; $display("[TB] FAIL valley_pulse got=%0b exp=1", turn_pulse); end
        total++; if (turn_is_peak !== 1'b0) begin bad++; $display("[TB] FAIL valley_flag got=%0b exp=0", turn_is_peak); end
        total++; if (extreme_value !== 14'd100) begin bad++; $display("[TB] FAIL valley_value got=%0d exp=100", extreme_value); end
        total++; if (rising !== 1'b1 || turn_count !== 32'd2) begin bad++; $display("[TB] FAIL valley_state got=r%0b c%0d exp=r1 c2", rising, turn_count); end
    endtask

    task automatic test_threshold_equal();
        send(14'd170);
        send(14'd160);
        send(14'd150);
        total++; if (rising !== 1'b1 || turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL equal_thresh got=r%0b p%0b exp=r1 p0", rising, turn_pulse); end
    endtask

    task automatic test_signed_extremes();
        do_reset();
        confirm_len = 8'd1;
        send(14'h2000);
        send(14'h1FFF);
        total++; if (rising !== 1'b1 || turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL signed_up got=r%0b p%0b exp=r1 p0", rising, turn_pulse); end
        send(14'h2000);
        total++; if (turn_pulse !== 1'b1 || turn_is_peak !== 1'b1) begin bad++; $display("[TB] FAIL signed_peak got=p%0b k%0b exp=p1 k1", turn_pulse, turn_is_peak); end
        total++; if (extreme_value !== 14'h1FFF) begin bad++; $display("[TB] FAIL signed_peak_value got=%0h exp=1fff", extreme_value); end
        total++; if (falling !== 1'b1) begin bad++; $display("[TB] FAIL signed_down got=%0b exp=1", falling); end
        send(14'h1FFF);
        total++; if (extreme_value !== 14'h2000 || turn_is_peak !== 1'b0) begin bad++; $display("[TB] FAIL signed_valley got=%0h k%0b exp=2000 k0", extreme_value, turn_is_peak); end
        total++; if (turn_count !== 32'd2) begin bad++; $display("[TB] FAIL signed_count got=%0d exp=2", turn_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        threshold = 12'd10;
        confirm_len = 8'd0;
        send(14'd0);
        send(14'd100);
        total++; if (rising !== 1'b1) begin bad++; $display("[TB] FAIL confirm_zero got=%0b exp=1", rising); end
        send(14'd500);
        do_reset();
        total++; if ({rising, falling, turn_pulse, turn_is_peak} !== 4'b0000 || extreme_value !== 14'd0 || turn_count !== 32'd0) begin
            bad++; $display("[TB] FAIL mid_reset got=r%0b f%0b p%0b k%0b e%0d c%0d exp=all0", rising, falling, turn_pulse, turn_is_peak, extreme_value, turn_count);
        end
        send(14'd300);
        total++; if ({rising, falling, turn_pulse} !== 3'b000 || turn_count !== 32'd0) begin bad++; $display("[TB] FAIL post_reset_first got=r%0b f%0b p%0b c%0d exp=0", rising, falling, turn_pulse, turn_count); end
        send(14'd50);
        total++; if (falling !== 1'b1 || turn_pulse !== 1'b0 || turn_count !== 32'd0) begin bad++; $display("[TB] FAIL post_reset_fall got=f%0b p%0b c%0d exp=f1 p0 c0", falling, turn_pulse, turn_count); end
    endtask

    task automatic test_back_to_back();
        confirm_len = 8'd2;
        @(negedge adc_clk); din_valid = 1'b1; din = 14'd30;
        @(negedge adc_clk); din = 14'd60;
        @(negedge adc_clk); din = 14'd80;
        total++; if (turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL b2b_early got=%0b exp=0", turn_pulse); end
        @(negedge adc_clk); din = 14'd100;
        total++; if (turn_pulse !== 1'b1 || extreme_value !== 14'd30 || turn_is_peak !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valley got=p%0b e%0d k%0b exp=p1 e30 k0", turn_pulse, extreme_value, turn_is_peak); end
        @(negedge adc_clk); din_valid = 1'b0;
        total++; if (turn_pulse !== 1'b0 || rising !== 1'b1 || turn_count !== 32'd1) begin bad++; $display("[TB] FAIL b2b_after got=p%0b r%0b c%0d exp=p0 r1 c1", turn_pulse, rising, turn_count); end
    endtask

    task automatic test_confirm_change();
        confirm_len = 8'd5;
        send(14'd80);
        send(14'd60);
        send(14'd40);
        total++; if (rising !== 1'b1 || turn_pulse !== 1'b0) begin bad++; $display("[TB] FAIL change_hold got=r%0b p%0b exp=r1 p0", rising, turn_pulse); end
        confirm_len = 8'd2;
        send(14'd20);
        total++; if (turn_pulse !== 1'b1 || extreme_value !== 14'd100 || falling !== 1'b1) begin bad++; $display("[TB] FAIL change_switch got=p%0b e%0d f%0b exp=p1 e100 f1", turn_pulse, extreme_value, falling); end
        total++; if (turn_count !== 32'd2) begin bad++; $display("[TB] FAIL change_count got=%0d exp=2", turn_count); end
    endtask

    initial begin
        $display("[TB] slope_tracker directed test start");
        test_reset();
        test_rise();
        test_peak();
        test_noise();
        test_glitch();
        test_threshold_equal();
        test_signed_extremes();
        test_reset_mid();
        test_back_to_back();
        test_confirm_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slope_tracker.md
Name: slope_tracker

Overview:
Parametrised successor to the two-flag rising/falling detector. Classifies a sampled ADC stream, typically the Mossbauer drive-velocity or monitor waveform, as rising or falling. It uses a run-time threshold, a run-time confirmation count for noise immunity, and overflow-safe widened arithmetic. On each confirmed direction reversal it emits a one-cycle turn event carrying the captured peak or valley value and a running turn count. It sits downstream of the ADC capture path and feeds sweep-phase and channel-advance logic.

Parameters:
DATA_WIDTH, 14, sample width.
THRESH_WIDTH, 12, width of the unsigned threshold input.
CONFIRM_WIDTH, 8, width of the confirmation-length input.
SIGNED_DATA, 1, 1 = din is two's complement; 0 = din is unsigned.

Ports:
adc_clk  in  1  sole clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
din_valid  in  1  din is a new sample this cycle.
din  in  DATA_WIDTH  ADC sample.
threshold  in  THRESH_WIDTH  minimum step magnitude (unsigned) to count as up or down.
confirm_len  in  CONFIRM_WIDTH  consecutive opposing steps needed to change direction; 0 is treated as 1.
rising  out  1  level, state is RISING.
falling  out  1  level, state is FALLING.
turn_pulse  out  1  one-cycle pulse on a confirmed reversal.
turn_is_peak  out  1  1 = last turn was a peak (RISING->FALLING); 0 = valley.
extreme_value  out  DATA_WIDTH  peak or valley value of the last turn.
turn_count  out  32  number of turns since reset; wraps modulo 2^32.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) sets state IDLE and clears all outputs, prev_sample, counter and tracker to 0. Reset mid-operation discards all history. No turn_pulse is issued on reset.
- Cycles with din_valid=0 change nothing; turn_pulse is 0 on those cycles.
- Step arithmetic: delta = din - prev_sample, computed in DATA_WIDTH+1 bits with the mode set by SIGNED_DATA. Classification:
  - UP if delta > +threshold.
  - DOWN if delta < -threshold.
  - FLAT otherwise. Equality with threshold is FLAT.
  - Threshold is zero-extended; no wrap is possible.
- prev_sample is loaded with din on every valid sample.
- States:
  - IDLE: first valid sample loads prev_sample, then go to UNKNOWN.
  - UNKNOWN: count consecutive UP or DOWN steps. A step of the other direction restarts the count at 1 for that direction; FLAT holds the count. Reaching confirm_len enters RISING or FALLING with no turn_pulse. The tracker loads the current din.
  - RISING: DOWN increments cnt, UP clears cnt, FLAT holds cnt. tracker = max(tracker, din) on every valid sample, including during confirmation. When cnt reaches confirm_len:
    - go to FALLING;
    - turn_pulse=1, turn_is_peak=1;
    - extreme_value = tracker, with the current sample included in the max;
    - turn_count+1;
    - tracker reloads din; cnt cleared.
  - FALLING: mirror of RISING. Track min, valley event with turn_is_peak=0.
- Latency: all outputs are registered. They change at the clock edge after the edge sampling the deciding din_valid sample (1 cycle).
- rising and falling are never both 1; both are 0 in IDLE and UNKNOWN.
- extreme_value and turn_is_peak hold until the next turn.
- confirm_len or threshold changed mid-run takes effect on the next valid sample. If cnt is already >= the new confirm_len, the next opposing step triggers the switch.

Decomposition:
- Package slope_tracker_pkg:
  - state enum {IDLE, UNKNOWN, RISING, FALLING};
  - step-class enum {FLAT, UP, DOWN};
  - a function for a widened signed/unsigned compare.
- One natural sub-module, step_classifier: registered-free combinational delta and classify from din, prev_sample and threshold. The FSM, counter, tracker and event registers live in the top.

Test Plan:
- Reset then threshold=10, confirm_len=3, samples 0,20,40,60 (each valid) -> rising=1 one cycle after sample 60; no turn_pulse; turn_count=0.
- Continue 80..200 step 20, then 180,160,140 -> turn_pulse one cycle after 140; turn_is_peak=1; extreme_value=200; falling=1; turn_count=1.
- Noise in FALLING: samples alternating 140,145,140,135 with threshold=10 -> all FLAT; state unchanged; no pulse.
- Glitch rejection in FALLING (confirm_len=3): 120,100,130,110,140,160,180 -> the UP at 130 is cleared by the DOWN at 110; the switch happens only at 180; valley extreme_value=100; turn_is_peak=0.
- Signed extremes (SIGNED_DATA=1, DATA_WIDTH=14, confirm_len=1) -> samples -8192 then 8191 classify UP with delta=16383 and no overflow; 8191 then -8192 classify DOWN; events show peak 8191.
- Reset mid-RISING with tracker=500 -> all outputs 0 the next cycle; first post-reset sample produces no event; turn_count restarts at 0. Also check confirm_len=0 behaves as confirm_len=1.
